// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - round-robin arbiter sharing one 2:1 mux between requesters A and B
module mux_share_arbiter #(
  parameter int WIDTH    = 3,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int              CW      = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          last_q, last_d;  // side served most recently: 0=A, 1=B
  logic          beat_a, beat_b;

  assign sel      = (state_q == GNT_B);
  assign out_data = sel ? data_b : data_a;
  assign beat_a   = (state_q == GNT_A) && req_a && out_ready;
  assign beat_b   = (state_q == GNT_B) && req_b && out_ready;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_q)) state_d = GNT_A;
        else if (req_b)                  state_d = GNT_B;
      end
      GNT_A: begin
        out_valid = req_a;
        gnt_a     = out_ready;
        if (!req_a) begin
          state_d = req_b ? GNT_B : IDLE;
          last_d  = 1'b0;
        end else if (beat_a && (beat_cnt_q == CNT_MAX) && req_b) begin
          state_d = GNT_B;
          last_d  = 1'b0;
        end else if (beat_a && (beat_cnt_q != CNT_MAX)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      GNT_B: begin
        out_valid = req_b;
        gnt_b     = out_ready;
        if (!req_b) begin
          state_d = req_a ? GNT_A : IDLE;
          last_d  = 1'b1;
        end else if (beat_b && (beat_cnt_q == CNT_MAX) && req_a) begin
          state_d = GNT_A;
          last_d  = 1'b1;
        end else if (beat_b && (beat_cnt_q != CNT_MAX)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) beat_cnt_d = '0;
    // No handshake may complete while reset is held.
    if (!rst_n) begin
      gnt_a     = 1'b0;
      gnt_b     = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end

endmodule
